// File: rtl/qpu_pkg.sv
// Shared types and instruction-field constants for the QPU issue controller.
package qpu_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  localparam logic [5:0] OPC_COP2 = 6'b010010;
  localparam int MEAS_BIT = 25;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 11;

endpackage

// File: rtl/qpu_watchdog.sv
// Clear/enable cycle counter; expired flags the last allowed WAIT cycle.
module qpu_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/qpu_issue_ctrl.sv
// Sequences one COP2 instruction into the QPU: stall core, issue over valid/ready,
// wait for done under a watchdog, optionally write the measurement back to the regfile.
module qpu_issue_ctrl
  import qpu_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int RES_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               quantum_en,
  input  logic [INSTR_W-1:0] instr,
  output logic               cpu_stall,
  output logic               busy,
  output logic               qpu_cmd_valid,
  output logic [INSTR_W-1:0] qpu_cmd,
  input  logic               qpu_cmd_ready,
  input  logic               qpu_done,
  input  logic               qpu_err,
  input  logic [RES_W-1:0]   qpu_result,
  output logic               rf_we,
  output logic [4:0]         rf_waddr,
  output logic [RES_W-1:0]   rf_wdata,
  output logic               timeout_err,
  output logic               qpu_fault
);

  state_t             r_state, w_next;
  logic [INSTR_W-1:0] r_instr;
  logic [4:0]         r_waddr;
  logic [RES_W-1:0]   r_wdata;
  logic               w_accept, w_done, w_wr, w_expired;

  assign w_accept = (r_state == ISSUE) && qpu_cmd_ready;
  assign w_done   = (r_state == WAIT) && qpu_done;
  // r0 is hardwired, so a MEAS targeting rd=0 has nothing to write
  assign w_wr     = r_instr[MEAS_BIT] && (r_instr[RD_MSB:RD_LSB] != 5'd0);

  qpu_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_accept),
    .i_en      (r_state == WAIT),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (quantum_en) w_next = ISSUE;
      ISSUE: if (qpu_cmd_ready) w_next = WAIT;
      WAIT: begin
        if (qpu_done)       w_next = (!qpu_err && w_wr) ? WB : IDLE;
        else if (w_expired) w_next = IDLE;
      end
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      if (r_state == IDLE && quantum_en) begin
        r_instr <= instr;
        r_waddr <= instr[RD_MSB:RD_LSB];
      end
      if (w_done && !qpu_err && w_wr) r_wdata <= qpu_result;
    end
  end

  // Stall in IDLE follows quantum_en directly so the core freezes on the decode cycle
  always_comb begin
    cpu_stall     = 1'b1;
    busy          = (r_state != IDLE);
    qpu_cmd_valid = (r_state == ISSUE);
    rf_we         = (r_state == WB);
    timeout_err   = (r_state == WAIT) && w_expired && !qpu_done;
    qpu_fault     = w_done && qpu_err;
    if (r_state == IDLE) cpu_stall = quantum_en && rst_n;
  end

  assign qpu_cmd  = r_instr;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

endmodule

// File: tb/tb_qpu_issue_ctrl.sv
// Directed bench for qpu_issue_ctrl with a scoreboard for commands and result events.
module tb_qpu_issue_ctrl;

  localparam logic [2:0] EV_WR = 3'b100, EV_TO = 3'b010, EV_FLT = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        quantum_en;
  logic [31:0] instr;
  logic        cpu_stall, busy, qpu_cmd_valid;
  logic [31:0] qpu_cmd;
  logic        qpu_cmd_ready, qpu_done, qpu_err;
  logic [31:0] qpu_result;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        timeout_err, qpu_fault;

  int checks = 0;
  int errors = 0;
  ev_t         evq[$];
  logic [31:0] cmdq[$];

  always #5 clk = ~clk;

  qpu_issue_ctrl #(.INSTR_W(32), .RES_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .quantum_en(quantum_en), .instr(instr),
    .cpu_stall(cpu_stall), .busy(busy), .qpu_cmd_valid(qpu_cmd_valid), .qpu_cmd(qpu_cmd),
    .qpu_cmd_ready(qpu_cmd_ready), .qpu_done(qpu_done), .qpu_err(qpu_err),
    .qpu_result(qpu_result), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .timeout_err(timeout_err), .qpu_fault(qpu_fault)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: commands pop on handshake, result events pop whenever one is presented
  always @(negedge clk) begin
    if (qpu_cmd_valid === 1'b1 && qpu_cmd_ready === 1'b1) begin
      if (cmdq.size() == 0) chk("cmd_unexpected", 64'(qpu_cmd), 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("cmd_word", 64'(qpu_cmd), 64'(cmdq.pop_front()));
    end
    if (rf_we === 1'b1 || timeout_err === 1'b1 || qpu_fault === 1'b1) begin
      if (evq.size() == 0) begin
        chk("event_unexpected", 64'({rf_we, timeout_err, qpu_fault}), 64'd0);
      end else begin
        ev_t e;
        e = evq.pop_front();
        chk("event_kind", 64'({rf_we, timeout_err, qpu_fault}), 64'(e.kind));
        if (e.kind == EV_WR) begin
          chk("wb_addr", 64'(rf_waddr), 64'(e.addr));
          chk("wb_data", 64'(rf_wdata), 64'(e.data));
        end
      end
    end
  end

  // One instruction: ready after rdly cycles, done (or not) after ddly WAIT cycles
  task automatic do_op(input logic [31:0] ins, input int rdly, input int ddly,
                       input bit give_done, input bit err, input logic [31:0] res,
                       input bit qen_noise);
    ev_t e;
    bit  wr;
    wr = ins[25] && (ins[15:11] != 5'd0);
    cmdq.push_back(ins);
    quantum_en = 1'b1;
    instr      = ins;
    @(negedge clk);
    chk("c0_stall", 64'(cpu_stall), 64'd1);
    chk("c0_valid", 64'(qpu_cmd_valid), 64'd0);
    tick();
    quantum_en = 1'b0;
    instr      = 32'h1234_5678;
    for (int i = 0; i < rdly; i++) begin
      qpu_cmd_ready = 1'b0;
      @(negedge clk);
      chk("bp_valid", 64'(qpu_cmd_valid), 64'd1);
      chk("bp_cmd", 64'(qpu_cmd), 64'(ins));
      chk("bp_stall", 64'(cpu_stall), 64'd1);
      chk("bp_timeout", 64'(timeout_err), 64'd0);
      tick();
    end
    qpu_cmd_ready = 1'b1;
    @(negedge clk);
    chk("iss_valid", 64'(qpu_cmd_valid), 64'd1);
    tick();
    qpu_cmd_ready = 1'b0;
    for (int i = 0; i < ddly; i++) begin
      quantum_en = qen_noise;
      @(negedge clk);
      chk("wait_valid", 64'(qpu_cmd_valid), 64'd0);
      chk("wait_stall", 64'(cpu_stall), 64'd1);
      chk("wait_timeout", 64'(timeout_err), 64'd0);
      tick();
    end
    quantum_en = 1'b0;
    if (give_done) begin
      qpu_done   = 1'b1;
      qpu_err    = err;
      qpu_result = res;
      e.addr = ins[15:11];
      e.data = res;
      if (err) begin
        e.kind = EV_FLT;
        evq.push_back(e);
      end else if (wr) begin
        e.kind = EV_WR;
        evq.push_back(e);
      end
      @(negedge clk);
      chk("done_timeout", 64'(timeout_err), 64'd0);
      tick();
      qpu_done = 1'b0;
      qpu_err  = 1'b0;
      if (!err && wr) begin
        @(negedge clk);
        chk("wb_we", 64'(rf_we), 64'd1);
        chk("wb_stall", 64'(cpu_stall), 64'd1);
        tick();
      end
    end else begin
      e.kind = EV_TO;
      e.addr = '0;
      e.data = '0;
      evq.push_back(e);
      @(negedge clk);
      chk("to_pulse", 64'(timeout_err), 64'd1);
      chk("to_no_we", 64'(rf_we), 64'd0);
      tick();
    end
    @(negedge clk);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_stall", 64'(cpu_stall), 64'd0);
    chk("end_we", 64'(rf_we), 64'd0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; quantum_en = 1'b0; instr = '0; qpu_cmd_ready = 1'b0;
    qpu_done = 1'b0; qpu_err = 1'b0; qpu_result = '0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      quantum_en    = 1'($urandom);
      instr         = $urandom;
      qpu_cmd_ready = 1'($urandom);
      qpu_done      = 1'($urandom);
      qpu_err       = 1'($urandom);
      qpu_result    = $urandom;
      @(negedge clk);
      chk("rst_ctrl", 64'({cpu_stall, busy, qpu_cmd_valid, rf_we, timeout_err, qpu_fault}), 64'd0);
      chk("rst_cmd", 64'(qpu_cmd), 64'd0);
      chk("rst_waddr", 64'(rf_waddr), 64'd0);
      chk("rst_wdata", 64'(rf_wdata), 64'd0);
      tick();
    end
    rst_n = 1'b1; quantum_en = 1'b0; qpu_cmd_ready = 1'b0;
    qpu_done = 1'b0; qpu_err = 1'b0; qpu_result = '0;
    tick();

    do_op(32'h4A00_2800, 0, 0, 1'b1, 1'b0, 32'h0000_0001, 1'b0);
    do_op(32'h4A00_F800, 0, 3, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
    do_op(32'h4A00_2800, 5, 2, 1'b1, 1'b0, 32'h0000_00A5, 1'b0);
    do_op(32'h4A00_2800, 1, 15, 1'b0, 1'b0, 32'h0, 1'b0);
    do_op(32'h4A00_2800, 0, 15, 1'b1, 1'b0, 32'h0000_0F0F, 1'b0);
    do_op(32'h4800_2800, 0, 1, 1'b1, 1'b0, 32'h0000_0077, 1'b0);
    do_op(32'h4A00_0000, 0, 1, 1'b1, 1'b0, 32'h0000_0088, 1'b0);
    do_op(32'h4A00_2800, 0, 2, 1'b1, 1'b1, 32'h0000_0099, 1'b0);

    // Reset while waiting on the QPU
    cmdq.push_back(32'h4A00_1800);
    quantum_en = 1'b1; instr = 32'h4A00_1800;
    tick();
    quantum_en = 1'b0; qpu_cmd_ready = 1'b1;
    tick();
    qpu_cmd_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstw_ctrl", 64'({cpu_stall, busy, qpu_cmd_valid, rf_we, timeout_err, qpu_fault}), 64'd0);
    chk("rstw_cmd", 64'(qpu_cmd), 64'd0);
    chk("rstw_waddr", 64'(rf_waddr), 64'd0);
    chk("rstw_wdata", 64'(rf_wdata), 64'd0);
    tick();
    do_op(32'h4A00_2800, 0, 0, 1'b1, 1'b0, 32'h0000_0001, 1'b0);

    repeat (2) tick();
    chk("evq_empty", 64'(evq.size()), 64'd0);
    chk("cmdq_empty", 64'(cmdq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
